// File: rtl/shift_pkg.sv
// Shared definitions for the shifter issue/capture slice: default widths,
// FIFO depth, pointer width and the command record carried through the buffer.
package shift_pkg;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  // One buffered command: operand and the amount to shift it by.
  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] amt;
  } cmd_t;

  // Build a command record from its fields.
  function automatic cmd_t make_cmd(input logic [DW-1:0] data, input logic [AW-1:0] amt);
    cmd_t c;
    c.data = data;
    c.amt  = amt;
    return c;
  endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Command FIFO: storage, read/write pointers and occupancy count.
// Pointers wrap naturally; the count tells full apart from empty.
// Storage is deliberately left unreset; only the bookkeeping is cleared.
module shift_cmd_fifo
  import shift_pkg::*;
#(
  parameter int W     = shift_pkg::DW + shift_pkg::AW,
  parameter int DEPTH = shift_pkg::DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Write port into the unreset storage array.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = (count_r == CW'(DEPTH));
  assign empty   = (count_r == CW'(0));

endmodule

// File: rtl/shift_issue_ctrl.sv
// Command buffer and issue/capture controller in front of a combinational
// barrel shifter. The FIFO head drives the shifter; the shifter result is
// captured into a registered valid/ready output slot.
// Optional: define SHIFT_ISSUE_STATS_EN to add the issue_cnt (wrapping) and
// stall_cnt (saturating) statistics outputs.
module shift_issue_ctrl
  import shift_pkg::*;
#(
  parameter int DW    = shift_pkg::DW,
  parameter int AW    = shift_pkg::AW,
  parameter int DEPTH = shift_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_amt,
  output logic [DW-1:0] shf_data,
  output logic [AW-1:0] shf_amt,
  input  logic [DW-1:0] shf_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_amt
`ifdef SHIFT_ISSUE_STATS_EN
  ,
  output logic [15:0]   issue_cnt,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int CMD_W = DW + AW;

  logic              push_s;
  logic              issue_s;
  logic              full_s;
  logic              empty_s;
  logic [CMD_W-1:0]  head_s;
  logic              out_valid_r;
  logic [DW-1:0]     out_data_r;
  logic [AW-1:0]     out_amt_r;

  // No write-through: a full buffer refuses input even when a pop is happening.
  assign in_ready = !full_s;
  assign push_s   = in_valid && !full_s;
  assign issue_s  = !empty_s && (!out_valid_r || out_ready);

  shift_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .pop     (issue_s),
    .wr_data ({in_data, in_amt}),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Present the head command to the shifter, or zeros when nothing is buffered.
  always_comb begin
    shf_data = {DW{1'b0}};
    shf_amt  = {AW{1'b0}};
    if (!empty_s) begin
      shf_data = head_s[CMD_W-1:AW];
      shf_amt  = head_s[AW-1:0];
    end else begin
      shf_data = {DW{1'b0}};
      shf_amt  = {AW{1'b0}};
    end
  end

  // Output slot: capture on issue, retire on acceptance, otherwise hold steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      out_amt_r   <= {AW{1'b0}};
    end else if (issue_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= shf_result;
      out_amt_r   <= shf_amt;
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
      out_data_r  <= out_data_r;
      out_amt_r   <= out_amt_r;
    end else begin
      out_valid_r <= out_valid_r;
      out_data_r  <= out_data_r;
      out_amt_r   <= out_amt_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_amt   = out_amt_r;

`ifdef SHIFT_ISSUE_STATS_EN
  logic [15:0] issue_cnt_r;
  logic [15:0] stall_cnt_r;

  // Issue count wraps; stall count saturates so long stalls stay visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_r <= 16'h0000;
      stall_cnt_r <= 16'h0000;
    end else begin
      if (issue_s) begin
        issue_cnt_r <= issue_cnt_r + 16'h0001;
      end else begin
        issue_cnt_r <= issue_cnt_r;
      end
      if (out_valid_r && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign issue_cnt = issue_cnt_r;
  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Self-checking bench for shift_issue_ctrl. A rotate-left shifter model sits
// between shf_* and shf_result; a scoreboard queue holds expected results
// pushed at accept time and compared against captured outputs.
module tb_shift_issue_ctrl;
  import shift_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_amt;
  logic [DW-1:0] shf_data;
  logic [AW-1:0] shf_amt;
  logic [DW-1:0] shf_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_amt;
`ifdef SHIFT_ISSUE_STATS_EN
  logic [15:0]   issue_cnt;
  logic [15:0]   stall_cnt;
`endif

  int passed = 0;
  int total  = 0;
  cmd_t exp_q[$];
  cmd_t obs_q[$];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] d, input logic [AW-1:0] a);
    logic [2*DW-1:0] w;
    w = {d, d} << a;
    return w[2*DW-1:DW];
  endfunction

  assign shf_result = rotl(shf_data, shf_amt);

  shift_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .shf_data   (shf_data),
    .shf_amt    (shf_amt),
    .shf_result (shf_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_amt    (out_amt)
`ifdef SHIFT_ISSUE_STATS_EN
    ,
    .issue_cnt  (issue_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Record handshakes seen before the edge, then advance one cycle (sample point #1 after posedge).
  task automatic clk_step();
    if (in_valid && in_ready) exp_q.push_back(make_cmd(rotl(in_data, in_amt), in_amt));
    if (out_valid && out_ready) obs_q.push_back(make_cmd(out_data, out_amt));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b0;
    for (int i = 0; i < cycles; i++) clk_step();
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    do_reset(2);
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h expected 00", out_data); else passed++;
    total++; if (out_amt !== 3'd0) $display("FAIL reset_out_amt: got %0d expected 0", out_amt); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
    total++; if ({shf_data, shf_amt} !== 11'h000) $display("FAIL reset_shf: got %h/%0d expected 00/0", shf_data, shf_amt); else passed++;
`ifdef SHIFT_ISSUE_STATS_EN
    total++; if ({issue_cnt, stall_cnt} !== 32'h0) $display("FAIL reset_stats: got %h/%h expected 0/0", issue_cnt, stall_cnt); else passed++;
`endif
  endtask

  task automatic test_single();
    cmd_t e, o;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hF0; in_amt = 3'd1;
    clk_step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL single_early_valid: got %b expected 0", out_valid); else passed++;
    total++; if ({shf_data, shf_amt} !== {8'hF0, 3'd1}) $display("FAIL single_head: got %h/%0d expected f0/1", shf_data, shf_amt); else passed++;
    clk_step();
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid); else passed++;
    total++; if ({out_data, out_amt} !== {8'hE1, 3'd1}) $display("FAIL single_result: got %h/%0d expected e1/1", out_data, out_amt); else passed++;
    clk_step();
    total++; if (out_valid !== 1'b0) $display("FAIL single_drop: got %b expected 0", out_valid); else passed++;
    total++;
    if (exp_q.size() != 1 || obs_q.size() != 1) $display("FAIL single_count: got %0d results expected %0d", obs_q.size(), exp_q.size());
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) $display("FAIL single_sb: got %h/%0d expected %h/%0d", o.data, o.amt, e.data, e.amt); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_burst();
    logic [7:0] tbl [8];
    bit ready_low, bubble;
    int guard;
    cmd_t o;
    tbl = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0};
    ready_low = 1'b0; bubble = 1'b0; guard = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'h81; in_amt = AW'(i);
      if (in_ready !== 1'b1) ready_low = 1'b1;
      if (!out_valid && obs_q.size() > 0 && obs_q.size() < 8) bubble = 1'b1;
      clk_step();
    end
    in_valid = 1'b0;
    while (obs_q.size() < 8 && guard < 20) begin
      if (!out_valid && obs_q.size() > 0) bubble = 1'b1;
      clk_step();
      guard++;
    end
    total++; if (ready_low) $display("FAIL burst_in_ready: got 0 during burst expected 1"); else passed++;
    total++; if (bubble) $display("FAIL burst_bubble: got gap in out_valid expected none"); else passed++;
    total++;
    if (obs_q.size() != 8) $display("FAIL burst_count: got %0d results expected 8", obs_q.size());
    else begin
      passed++;
      for (int k = 0; k < 8; k++) begin
        o = obs_q[k];
        total++;
        if (o.data !== tbl[k] || o.amt !== AW'(k)) $display("FAIL burst_result_%0d: got %h/%0d expected %h/%0d", k, o.data, o.amt, tbl[k], k);
        else passed++;
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    int accepted, guard;
    logic [DW-1:0] first;
    bit unstable;
    cmd_t e, o;
    do_reset(1);
    accepted = 0; guard = 0; unstable = 1'b0;
    while (accepted < 5 && guard < 20) begin
      in_valid = 1'b1; in_data = DW'($urandom); in_amt = AW'($urandom);
      if (in_ready) accepted++;
      clk_step();
      guard++;
    end
    in_valid = 1'b0;
    total++; if (accepted != 5) $display("FAIL bp_accepted: got %0d expected 5", accepted); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b expected 0", in_ready); else passed++;
    first = out_data;
    total++;
    if (exp_q.size() == 0 || first !== exp_q[0].data) $display("FAIL bp_first: got %h expected first result", first);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      if (out_data !== first || out_valid !== 1'b1 || in_ready !== 1'b0) unstable = 1'b1;
    end
    total++; if (unstable) $display("FAIL bp_hold: got output change under stall expected stable %h", first); else passed++;
    out_ready = 1'b1; guard = 0;
    while (obs_q.size() < 5 && guard < 20) begin clk_step(); guard++; end
    total++; if (out_valid !== 1'b0) $display("FAIL bp_drop: got %b expected 0", out_valid); else passed++;
    total++;
    if (obs_q.size() != 5 || exp_q.size() != 5) $display("FAIL bp_count: got %0d results expected %0d", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) $display("FAIL bp_order: got %h/%0d expected %h/%0d", o.data, o.amt, e.data, e.amt); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_full_pop();
    int accepted, guard;
    cmd_t e, o;
    do_reset(1);
    accepted = 0; guard = 0;
    while (accepted < 5 && guard < 20) begin
      in_valid = 1'b1; in_data = DW'(8'h11 * (accepted + 1)); in_amt = AW'(accepted + 2);
      if (in_ready) accepted++;
      clk_step();
      guard++;
    end
    in_valid = 1'b1; in_data = 8'hA5; in_amt = 3'd5; out_ready = 1'b1;
    total++; if (in_ready !== 1'b0) $display("FAIL fullpop_ready_low: got %b expected 0", in_ready); else passed++;
    clk_step();
    total++; if (in_ready !== 1'b1) $display("FAIL fullpop_ready_high: got %b expected 1", in_ready); else passed++;
    clk_step();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) clk_step();
    total++; if (out_valid !== 1'b0) $display("FAIL fullpop_idle: got %b expected 0", out_valid); else passed++;
    total++;
    if (obs_q.size() != 6 || exp_q.size() != 6) $display("FAIL fullpop_count: got %0d results expected 6 (%0d queued)", obs_q.size(), exp_q.size());
    else passed++;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++;
      if (o !== e) $display("FAIL fullpop_order: got %h/%0d expected %h/%0d", o.data, o.amt, e.data, e.amt); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    bit stale;
    cmd_t e, o;
    do_reset(1);
    stale = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(8'h3C + i); in_amt = AW'(i + 1);
      clk_step();
    end
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL rmid_pending: got %b expected 1", out_valid); else passed++;
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    exp_q.delete(); obs_q.delete();
    total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL rmid_data: got %h expected 00", out_data); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rmid_ready: got %b expected 1", in_ready); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0) stale = 1'b1;
      clk_step();
    end
    total++; if (stale) $display("FAIL rmid_stale: got out_valid after reset expected 0"); else passed++;
    in_valid = 1'b1; in_data = 8'h96; in_amt = 3'd3;
    clk_step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) clk_step();
    total++;
    if (obs_q.size() != 1 || exp_q.size() != 1) $display("FAIL rmid_count: got %0d results expected 1", obs_q.size());
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o !== e) $display("FAIL rmid_result: got %h/%0d expected %h/%0d", o.data, o.amt, e.data, e.amt); else passed++;
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef SHIFT_ISSUE_STATS_EN
  task automatic test_stats();
    do_reset(1);
    in_valid = 1'b1; in_data = 8'h01; in_amt = 3'd0;
    clk_step();
    in_valid = 1'b0;
    clk_step();
    for (int i = 0; i < 3; i++) clk_step();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_data = DW'(i + 2); in_amt = AW'(i);
      clk_step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) clk_step();
    total++; if (issue_cnt !== 16'd10) $display("FAIL stats_issue: got %0d expected 10", issue_cnt); else passed++;
    total++; if (stall_cnt !== 16'd3) $display("FAIL stats_stall: got %0d expected 3", stall_cnt); else passed++;
    total++; if (obs_q.size() != 10) $display("FAIL stats_results: got %0d expected 10", obs_q.size()); else passed++;
    force dut.issue_cnt_r = 16'hFFFF;
    #1;
    release dut.issue_cnt_r;
    in_valid = 1'b1; in_data = 8'h42; in_amt = 3'd2;
    clk_step();
    in_valid = 1'b0;
    total++; if (issue_cnt !== 16'hFFFF) $display("FAIL stats_preload: got %h expected ffff", issue_cnt); else passed++;
    clk_step();
    total++; if (issue_cnt !== 16'h0000) $display("FAIL stats_wrap: got %h expected 0000", issue_cnt); else passed++;
    for (int i = 0; i < 3; i++) clk_step();
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b0;
    #1;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
`ifdef SHIFT_ISSUE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
